// File: rtl/alu_result_stage_if.sv
// ALU-to-stage and stage-to-writeback handshake bundles.
// Producer side is master, consumer side is slave.
interface alu_result_stage_in_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_result;
  logic              in_carry;
  logic              in_overflow;
  logic              in_zero;
  logic              in_parity;
  logic [REG_AW-1:0] in_rd;
  logic              in_wr_en;
  logic              in_set_flags;

  modport master (
    output in_valid,
    output in_result,
    output in_carry,
    output in_overflow,
    output in_zero,
    output in_parity,
    output in_rd,
    output in_wr_en,
    output in_set_flags,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_result,
    input  in_carry,
    input  in_overflow,
    input  in_zero,
    input  in_parity,
    input  in_rd,
    input  in_wr_en,
    input  in_set_flags,
    output in_ready
  );
endinterface

interface alu_result_stage_out_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [REG_AW-1:0] out_rd;
  logic              out_wr_en;

  modport master (
    output out_valid,
    output out_result,
    output out_rd,
    output out_wr_en,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_result,
    input  out_rd,
    input  out_wr_en,
    output out_ready
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer toward writeback,
// architectural flag register and retire counter.
module alu_result_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_AW     = 5,
  parameter bit ZERO_WIRED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  alu_result_stage_in_if.slave   i_ex,
  alu_result_stage_out_if.master o_wb,
  output logic                   flag_c,
  output logic                   flag_v,
  output logic                   flag_z,
  output logic                   flag_p,
  output logic [WIDTH-1:0]       retire_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0]  result;
    logic              c;
    logic              v;
    logic              z;
    logic              p;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              set_flags;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  entry_t           r_head;
  entry_t           r_tail;
  entry_t           w_head_nxt;
  entry_t           w_tail_nxt;
  entry_t           w_in;
  logic             r_in_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  logic             w_rd_zero;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_flag_z;
  logic             r_flag_p;
  logic [WIDTH-1:0] r_retire_cnt;

  assign w_in = '{
    result:    i_ex.in_result,
    c:         i_ex.in_carry,
    v:         i_ex.in_overflow,
    z:         i_ex.in_zero,
    p:         i_ex.in_parity,
    rd:        i_ex.in_rd,
    wr_en:     i_ex.in_wr_en,
    set_flags: i_ex.in_set_flags
  };

  assign w_push = i_ex.in_valid
                & r_in_ready
                & ~flush;

  assign w_out_valid = (r_state != EMPTY)
                     & ~flush;

  assign w_pop = w_out_valid
               & o_wb.out_ready;

  assign w_rd_zero = (r_head.rd == '0);

  // Next buffer state and entry contents; flush wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_head_nxt  = w_in;
          end
        end
        ONE: begin
          unique case (1'b1)
            (w_push & ~w_pop): begin
              w_state_nxt = FULL;
              w_tail_nxt  = w_in;
            end
            (~w_push & w_pop): begin
              w_state_nxt = EMPTY;
              w_head_nxt  = '0;
            end
            (w_push & w_pop): begin
              w_head_nxt  = w_in;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (w_pop) begin
            w_state_nxt = ONE;
            w_head_nxt  = r_tail;
            w_tail_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_head_nxt  = '0;
          w_tail_nxt  = '0;
        end
      endcase
    end
  end

  // Buffer state and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  // Registered ready: low in reset, then high whenever not full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  // Architectural flags load from the retiring entry when it asks to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
      r_flag_z <= 1'b1;
      r_flag_p <= 1'b1;
    end else if (w_pop && r_head.set_flags) begin
      r_flag_c <= r_head.c;
      r_flag_v <= r_head.v;
      r_flag_z <= r_head.z;
      r_flag_p <= r_head.p;
    end
  end

  // Free-running retire count, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_pop) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign i_ex.in_ready   = r_in_ready;
  assign o_wb.out_valid  = w_out_valid;
  assign o_wb.out_result = r_head.result;
  assign o_wb.out_rd     = r_head.rd;
  assign o_wb.out_wr_en  = r_head.wr_en
                         & ~(ZERO_WIRED & w_rd_zero);

  assign flag_c     = r_flag_c;
  assign flag_v     = r_flag_v;
  assign flag_z     = r_flag_z;
  assign flag_p     = r_flag_p;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed plus random bench for alu_result_stage,
// checked against a queue-based reference model.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        flag_c;
  logic        flag_v;
  logic        flag_z;
  logic        flag_p;
  logic [31:0] retire_cnt;

  alu_result_stage_in_if  ex_if ();
  alu_result_stage_out_if wb_if ();

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .i_ex       (ex_if.slave),
    .o_wb       (wb_if.master),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .flag_z     (flag_z),
    .flag_p     (flag_p),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    bit          c;
    bit          v;
    bit          z;
    bit          p;
    logic [4:0]  rd;
    bit          wr;
    bit          sf;
  } ent_t;

  ent_t        q[$];
  bit          m_c;
  bit          m_v;
  bit          m_z;
  bit          m_p;
  logic [31:0] m_cnt;
  bit          m_ready;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input logic [31:0] r,
                     input logic [4:0] rd, input bit wr,
                     input bit sf, input bit c, input bit ov,
                     input bit z, input bit p);
    ex_if.in_valid     = v;
    ex_if.in_result    = r;
    ex_if.in_rd        = rd;
    ex_if.in_wr_en     = wr;
    ex_if.in_set_flags = sf;
    ex_if.in_carry     = c;
    ex_if.in_overflow  = ov;
    ex_if.in_zero      = z;
    ex_if.in_parity    = p;
  endtask

  task automatic idle();
    drv(0, 32'h0, 5'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_c     = 0;
    m_v     = 0;
    m_z     = 1;
    m_p     = 1;
    m_cnt   = '0;
    m_ready = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ovalid"}, wb_if.out_valid, 0);
    chk({tag, "_iready"}, ex_if.in_ready, 0);
    chk({tag, "_ores"}, wb_if.out_result, 0);
    chk({tag, "_ord"}, wb_if.out_rd, 0);
    chk({tag, "_owr"}, wb_if.out_wr_en, 0);
    chk({tag, "_flags"},
        {flag_c, flag_v, flag_z, flag_p}, 4'b0011);
    chk({tag, "_cnt"}, retire_cnt, 0);
  endtask

  task automatic check_outputs();
    bit m_valid;
    m_valid = (q.size() != 0) && !flush;
    chk("out_valid", wb_if.out_valid, m_valid);
    chk("in_ready", ex_if.in_ready, m_ready);
    if (m_valid) begin
      chk("out_result", wb_if.out_result, q[0].res);
      chk("out_rd", wb_if.out_rd, q[0].rd);
      chk("out_wr_en", wb_if.out_wr_en,
          q[0].wr && (q[0].rd != 0));
    end
    chk("flags", {flag_c, flag_v, flag_z, flag_p},
        {m_c, m_v, m_z, m_p});
    chk("retire_cnt", retire_cnt, m_cnt);
  endtask

  task automatic tick();
    bit   pu;
    bit   po;
    ent_t e;
    ent_t h;
    #1;
    check_outputs();
    pu = ex_if.in_valid && m_ready && !flush;
    po = (q.size() != 0) && !flush && wb_if.out_ready;
    e = '{res: ex_if.in_result, c: ex_if.in_carry,
          v: ex_if.in_overflow, z: ex_if.in_zero,
          p: ex_if.in_parity, rd: ex_if.in_rd,
          wr: ex_if.in_wr_en, sf: ex_if.in_set_flags};
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (po) begin
        h = q.pop_front();
        m_cnt = m_cnt + 1;
        if (h.sf) begin
          m_c = h.c;
          m_v = h.v;
          m_z = h.z;
          m_p = h.p;
        end
      end
      if (pu) q.push_back(e);
    end
    m_ready = (q.size() < 2);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    wb_if.out_ready = 1'b0;
    idle();
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single op, pop updates flags and count
    wb_if.out_ready = 1'b1;
    drv(1, 32'h5, 5'd3, 1, 1, 0, 0, 0, 1);
    tick();
    idle();
    tick();
    tick();
    chk("t1_flag_z", flag_z, 0);
    chk("t1_flag_p", flag_p, 1);
    chk("t1_cnt", retire_cnt, 1);

    // 2: back-to-back A,B,C against a stalled consumer
    wb_if.out_ready = 1'b0;
    drv(1, 32'hA0A0_0001, 5'd1, 1, 1, 1, 0, 0, 0);
    tick();
    drv(1, 32'hB0B0_0002, 5'd2, 1, 0, 0, 1, 0, 1);
    tick();
    drv(1, 32'hC0C0_0003, 5'd4, 1, 1, 0, 1, 1, 0);
    tick();
    tick();
    chk("t2_full_ready", ex_if.in_ready, 0);
    wb_if.out_ready = 1'b1;
    tick();
    tick();
    idle();
    tick();
    tick();

    // 3: push and pop together in ONE
    wb_if.out_ready = 1'b0;
    drv(1, 32'h1111_0000, 5'd7, 1, 0, 0, 0, 0, 0);
    tick();
    wb_if.out_ready = 1'b1;
    drv(1, 32'hD000_000D, 5'd9, 1, 1, 1, 1, 0, 0);
    tick();
    idle();
    wb_if.out_ready = 1'b0;
    tick();
    chk("t3_ready_one", ex_if.in_ready, 1);
    chk("t3_head_d", wb_if.out_result, 32'hD000_000D);
    wb_if.out_ready = 1'b1;
    tick();

    // 4: flush with two entries and a same-cycle input
    wb_if.out_ready = 1'b0;
    drv(1, 32'hE, 5'd5, 1, 1, 1, 1, 1, 1);
    tick();
    drv(1, 32'hF, 5'd6, 1, 1, 1, 1, 1, 1);
    tick();
    drv(1, 32'h6, 5'd8, 1, 1, 0, 0, 0, 0);
    flush = 1'b1;
    wb_if.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    tick();
    chk("t4_empty", wb_if.out_valid, 0);
    tick();

    // 5: rd=0 write suppressed, set_flags=0 leaves flags
    drv(1, 32'h77, 5'd0, 1, 1, 1, 0, 1, 0);
    tick();
    idle();
    tick();
    drv(1, 32'h88, 5'd10, 1, 0, 0, 1, 0, 1);
    tick();
    idle();
    tick();
    tick();

    // 6: counter wrap, then reset while full
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    drv(1, 32'h99, 5'd11, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    tick();
    chk("t6_wrap", retire_cnt, 0);
    wb_if.out_ready = 1'b0;
    drv(1, 32'h1234, 5'd12, 1, 1, 1, 1, 0, 0);
    tick();
    drv(1, 32'h5678, 5'd13, 1, 1, 0, 1, 0, 0);
    tick();
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 1), $urandom,
          5'($urandom_range(0, 31)),
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1));
      wb_if.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;
    idle();
    wb_if.out_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
